// File: rtl/nes_timing_gen_if.sv
// nes_timing_gen_if: control and status bundle of the NES master-clock
// timing generator.
//   master modport (console / debug side): drives region_pal, soft_reset,
//     halt, step; receives the enables, resets, phase, cycle count, state.
//   slave modport (nes_timing_gen): the reverse directions.
// MCLK and RESET_n are not part of the bundle; they stay plain ports.
interface nes_timing_gen_if #(
    parameter int CNT_W = 32
);
    logic             region_pal;
    logic             soft_reset;
    logic             halt;
    logic             step;
    logic             cpu_ce;
    logic             ppu_ce;
    logic             cpu_phi;
    logic             cpu_rst_n;
    logic             ppu_rst_n;
    logic [CNT_W-1:0] cycle_count;
    logic [1:0]       run_state;

    modport master (
        output region_pal, soft_reset, halt, step,
        input  cpu_ce, ppu_ce, cpu_phi, cpu_rst_n, ppu_rst_n, cycle_count, run_state
    );

    modport slave (
        input  region_pal, soft_reset, halt, step,
        output cpu_ce, ppu_ce, cpu_phi, cpu_rst_n, ppu_rst_n, cycle_count, run_state
    );
endinterface

// File: rtl/nes_timing_gen.sv
// nes_timing_gen: master-clock timing and reset sequencer for the NES core.
// Everything runs on MCLK; the CPU and PPU are driven by one-MCLK-wide clock
// enables, never by divided clocks.
// Ports:
//   MCLK     master clock, rising edge
//   RESET_n  asynchronous active-low reset
//   bus      nes_timing_gen_if.slave
//            in : region_pal (1 = PAL), soft_reset, halt (level), step (rising edge)
//            out: cpu_ce, ppu_ce, cpu_phi, cpu_rst_n, ppu_rst_n,
//                 cycle_count, run_state (0 hold, 1 run, 2 halted, 3 step)
module nes_timing_gen #(
    parameter int NTSC_CPU_DIV = 12,
    parameter int NTSC_PPU_DIV = 4,
    parameter int PAL_CPU_DIV  = 16,
    parameter int PAL_PPU_DIV  = 5,
    parameter int RST_HOLD_CYC = 8,
    parameter int CNT_W        = 32,
    parameter int DIV_W        = 5
) (
    input logic             MCLK,
    input logic             RESET_n,
    nes_timing_gen_if.slave bus
);
    localparam logic [1:0] ST_RST_HOLD = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_HALTED   = 2'd2;
    localparam logic [1:0] ST_STEP     = 2'd3;

    // Holds wrap indices up to RST_HOLD_CYC + 1.
    localparam int HOLD_W = $clog2(RST_HOLD_CYC + 2);

    logic              region_q;
    logic [DIV_W-1:0]  cpu_cnt;
    logic [DIV_W-1:0]  ppu_cnt;
    logic [DIV_W-1:0]  cpu_cnt_nxt;
    logic [DIV_W-1:0]  ppu_cnt_nxt;
    logic [DIV_W-1:0]  cpu_last;
    logic [DIV_W-1:0]  ppu_last;
    logic [DIV_W-1:0]  cpu_half;
    logic              cpu_wrap;
    logic              ppu_wrap;
    logic              gate_open;
    logic              step_q;
    logic              step_rise;
    logic              step_pend;
    logic [1:0]        state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              cpu_ce_q;
    logic              ppu_ce_q;
    logic              cpu_phi_q;
    logic              cpu_rst_q;
    logic              ppu_rst_q;
    logic [CNT_W-1:0]  cycle_cnt;

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        cpu_last    = region_q ? DIV_W'(PAL_CPU_DIV - 1) : DIV_W'(NTSC_CPU_DIV - 1);
        ppu_last    = region_q ? DIV_W'(PAL_PPU_DIV - 1) : DIV_W'(NTSC_PPU_DIV - 1);
        cpu_half    = region_q ? DIV_W'(PAL_CPU_DIV / 2) : DIV_W'(NTSC_CPU_DIV / 2);
        cpu_wrap    = (cpu_cnt == cpu_last);
        ppu_wrap    = (ppu_cnt == ppu_last);
        cpu_cnt_nxt = cpu_wrap ? '0 : cpu_cnt + DIV_W'(1);
        ppu_cnt_nxt = ppu_wrap ? '0 : ppu_cnt + DIV_W'(1);
        // Gating looks at the state before the edge, so the pulse of the
        // wrap that enters HALTED still goes out, and the one that leaves it
        // does not.
        gate_open   = (state != ST_HALTED);
        step_rise   = bus.step & ~step_q;
    end

    // Dividers, enables, phase and region latch. These never see soft_reset:
    // a soft reset must not shift the CPU/PPU phase.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge MCLK or negedge RESET_n) begin
        if (!RESET_n) begin
            cpu_cnt   <= '0;
            ppu_cnt   <= '0;
            region_q  <= 1'b0;
            cpu_ce_q  <= 1'b0;
            ppu_ce_q  <= 1'b0;
            cpu_phi_q <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            cpu_cnt   <= cpu_cnt_nxt;
            ppu_cnt   <= ppu_cnt_nxt;
            // Only a common wrap may switch divisors: both counters restart
            // at 0 together, so no runt pulse and no phase slip.
            if (cpu_wrap && ppu_wrap) begin
                region_q <= bus.region_pal;
            end
            cpu_ce_q  <= cpu_wrap && gate_open;
            ppu_ce_q  <= ppu_wrap && gate_open;
            // Registered from the next count so cpu_phi lines up with cpu_cnt.
            cpu_phi_q <= (cpu_cnt_nxt >= cpu_half);
            step_q    <= bus.step;
        end
    end

    // Run-state machine, reset sequencing and cycle counter.
    always_ff @(posedge MCLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state     <= ST_RST_HOLD;
            hold_cnt  <= '0;
            step_pend <= 1'b0;
            cpu_rst_q <= 1'b0;
            ppu_rst_q <= 1'b0;
            cycle_cnt <= '0;
        end else if (bus.soft_reset) begin
            state     <= ST_RST_HOLD;
            hold_cnt  <= '0;
            step_pend <= 1'b0;
            cpu_rst_q <= 1'b0;
            ppu_rst_q <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            // A pulse is counted on the edge that ends it, if the CPU was out
            // of reset while it was high.
            if (cpu_ce_q && cpu_rst_q) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end

            case (state)
                ST_RST_HOLD: begin
                    if (cpu_wrap) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                        // hold_cnt is the number of wraps already seen, so
                        // these fire on wrap RST_HOLD_CYC and RST_HOLD_CYC+1.
                        if (hold_cnt == HOLD_W'(RST_HOLD_CYC - 1)) begin
                            ppu_rst_q <= 1'b1;
                        end
                        if (hold_cnt == HOLD_W'(RST_HOLD_CYC)) begin
                            cpu_rst_q <= 1'b1;
                            state     <= bus.halt ? ST_HALTED : ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (cpu_wrap && bus.halt) begin
                        state <= ST_HALTED;
                    end
                end
                ST_HALTED: begin
                    if (cpu_wrap && step_pend) begin
                        state     <= ST_STEP;
                        step_pend <= 1'b0;
                    end else if (cpu_wrap && !bus.halt) begin
                        state     <= ST_RUN;
                        step_pend <= 1'b0;
                    end else if (step_rise) begin
                        step_pend <= 1'b1;
                    end
                end
                ST_STEP: begin
                    if (cpu_wrap) begin
                        state <= bus.halt ? ST_HALTED : ST_RUN;
                    end
                end
                default: begin
                    state <= ST_RST_HOLD;
                end
            endcase
        end
    end

    assign bus.cpu_ce      = cpu_ce_q;
    assign bus.ppu_ce      = ppu_ce_q;
    assign bus.cpu_phi     = cpu_phi_q;
    assign bus.cpu_rst_n   = cpu_rst_q;
    assign bus.ppu_rst_n   = ppu_rst_q;
    assign bus.cycle_count = cycle_cnt;
    assign bus.run_state   = state;
endmodule

// File: tb/tb_nes_timing_gen.sv
// tb_nes_timing_gen: directed plus randomized bench for nes_timing_gen.
// A behavioural model works from the MCLK edge number since the last phase
// origin: a wrap is "edge number divisible by the divisor", and the region is
// taken over when the edge number reaches the common period.
module tb_nes_timing_gen;
    localparam int NTSC_C = 12;
    localparam int NTSC_P = 4;
    localparam int PAL_C  = 16;
    localparam int PAL_P  = 5;
    localparam int HOLD   = 8;

    localparam int M_HOLD   = 0;
    localparam int M_RUN    = 1;
    localparam int M_HALTED = 2;
    localparam int M_STEP   = 3;

    logic MCLK    = 1'b0;
    logic RESET_n = 1'b1;

    always #5 MCLK = ~MCLK;

    nes_timing_gen_if #(.CNT_W(32)) bus ();

    nes_timing_gen dut (
        .MCLK    (MCLK),
        .RESET_n (RESET_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    int tick_no      = 0;
    int last_ce_tick = 0;
    int cpu_pulses   = 0;
    int ppu_pulses   = 0;

    // Model state.
    int          m_n;
    bit          m_pal;
    int          m_mode;
    int          m_hold;
    bit          m_pend;
    bit          m_step_prev;
    bit          m_cpu_rst;
    bit          m_ppu_rst;
    bit          m_cpu_ce;
    bit          m_ppu_ce;
    bit          m_phi;
    logic [31:0] m_count;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        m_n         = 0;
        m_pal       = 1'b0;
        m_mode      = M_HOLD;
        m_hold      = 0;
        m_pend      = 1'b0;
        m_step_prev = 1'b0;
        m_cpu_rst   = 1'b0;
        m_ppu_rst   = 1'b0;
        m_cpu_ce    = 1'b0;
        m_ppu_ce    = 1'b0;
        m_phi       = 1'b0;
        m_count     = '0;
    endtask

    task automatic model_edge();
        int dc;
        int dp;
        int span;
        bit cw;
        bit pw;
        bit pass;
        bit rise;
        dc   = m_pal ? PAL_C : NTSC_C;
        dp   = m_pal ? PAL_P : NTSC_P;
        span = m_pal ? 80 : 12;
        rise = bus.step && !m_step_prev;
        m_step_prev = bus.step;
        m_n++;
        cw   = (m_n % dc) == 0;
        pw   = (m_n % dp) == 0;
        pass = (m_mode != M_HALTED);
        if (bus.soft_reset) m_count = '0;
        else if (m_cpu_ce && m_cpu_rst) m_count++;
        m_cpu_ce = cw && pass;
        m_ppu_ce = pw && pass;
        if ((m_n % span) == 0) begin
            m_pal = bus.region_pal;
            m_n   = 0;
        end
        dc    = m_pal ? PAL_C : NTSC_C;
        m_phi = (m_n % dc) >= (dc / 2);
        if (bus.soft_reset) begin
            m_mode    = M_HOLD;
            m_hold    = 0;
            m_pend    = 1'b0;
            m_cpu_rst = 1'b0;
            m_ppu_rst = 1'b0;
        end else begin
            case (m_mode)
                M_HOLD: if (cw) begin
                    m_hold++;
                    if (m_hold == HOLD) m_ppu_rst = 1'b1;
                    if (m_hold == HOLD + 1) begin
                        m_cpu_rst = 1'b1;
                        m_mode    = bus.halt ? M_HALTED : M_RUN;
                    end
                end
                M_RUN: if (cw && bus.halt) m_mode = M_HALTED;
                M_HALTED: begin
                    if (cw && m_pend) begin
                        m_mode = M_STEP;
                        m_pend = 1'b0;
                    end else if (cw && !bus.halt) begin
                        m_mode = M_RUN;
                        m_pend = 1'b0;
                    end else if (rise) begin
                        m_pend = 1'b1;
                    end
                end
                default: if (cw) m_mode = bus.halt ? M_HALTED : M_RUN;
            endcase
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".cpu_ce"},      bus.cpu_ce,      m_cpu_ce);
        check({tag, ".ppu_ce"},      bus.ppu_ce,      m_ppu_ce);
        check({tag, ".cpu_phi"},     bus.cpu_phi,     m_phi);
        check({tag, ".cpu_rst_n"},   bus.cpu_rst_n,   m_cpu_rst);
        check({tag, ".ppu_rst_n"},   bus.ppu_rst_n,   m_ppu_rst);
        check({tag, ".cycle_count"}, bus.cycle_count, m_count);
        check({tag, ".run_state"},   bus.run_state,   m_mode);
    endtask

    task automatic tick();
        @(posedge MCLK);
        model_edge();
        #1;
        tick_no++;
        if (bus.cpu_ce === 1'b1) begin
            cpu_pulses++;
            last_ce_tick = tick_no;
        end
        if (bus.ppu_ce === 1'b1) ppu_pulses++;
        compare_all("model");
    endtask

    task automatic wait_cpu_ce(input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.cpu_ce !== 1'b1 && n < budget);
        check("wait_cpu_ce", bus.cpu_ce, 1'b1);
    endtask

    task automatic wait_state(input logic [1:0] value, input int budget);
        int n;
        n = 0;
        while (bus.run_state !== value && n < budget) begin
            tick();
            n++;
        end
        check("wait_state", bus.run_state, value);
    endtask

    task automatic async_reset(input bit pal);
        #2;
        RESET_n        = 1'b0;
        bus.halt       = 1'b0;
        bus.step       = 1'b0;
        bus.soft_reset = 1'b0;
        bus.region_pal = pal;
        #1;
        model_reset();
        compare_all("async_rst");
        repeat (2) @(posedge MCLK);
        @(negedge MCLK);
        RESET_n = 1'b1;
        tick_no = 0;
    endtask

    task automatic boot_checks(input string tag);
        for (int k = 1; k <= 14; k++) begin
            wait_cpu_ce(NTSC_C);
            check({tag, ".ce_tick"},   tick_no,       12 * k);
            check({tag, ".ppu_rst_n"}, bus.ppu_rst_n, (k >= 8));
            check({tag, ".cpu_rst_n"}, bus.cpu_rst_n, (k >= 9));
            check({tag, ".run_state"}, bus.run_state, (k >= 9) ? 2'd1 : 2'd0);
        end
        check({tag, ".count14"}, bus.cycle_count, 32'd5);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int q0;
        int prev_ce;
        logic [31:0] c0;

        bus.region_pal = 1'b0;
        bus.soft_reset = 1'b0;
        bus.halt       = 1'b0;
        bus.step       = 1'b0;

        // Reset, then NTSC boot sequence.
        async_reset(1'b0);
        boot_checks("boot");

        // Halt raised mid-period: one more pulse, then silence.
        wait_cpu_ce(20);
        repeat (5) tick();
        bus.halt = 1'b1;
        p0 = cpu_pulses;
        repeat (20) tick();
        check("halt.last_ce", cpu_pulses - p0, 1);
        check("halt.state",   bus.run_state, 2'd2);
        p0 = cpu_pulses;
        q0 = ppu_pulses;
        repeat (36) tick();
        check("halt.no_cpu", cpu_pulses - p0, 0);
        check("halt.no_ppu", ppu_pulses - q0, 0);
        c0 = bus.cycle_count;
        p0 = cpu_pulses;
        bus.halt = 1'b0;
        repeat (48) tick();
        check("resume.state",  bus.run_state, 2'd1);
        check("resume.pulses", cpu_pulses - p0, 3);
        check("resume.delta",  bus.cycle_count - c0, cpu_pulses - p0 - int'(bus.cpu_ce));

        // Single step while halted; a second step during STEP is ignored.
        bus.halt = 1'b1;
        repeat (20) tick();
        c0 = bus.cycle_count;
        p0 = cpu_pulses;
        q0 = ppu_pulses;
        bus.step = 1'b1;
        tick();
        tick();
        bus.step = 1'b0;
        wait_state(2'd3, 30);
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        repeat (30) tick();
        check("step.cpu_ce", cpu_pulses - p0, 1);
        check("step.ppu_ce", ppu_pulses - q0, 3);
        check("step.count",  bus.cycle_count, c0 + 32'd1);
        check("step.state",  bus.run_state, 2'd2);

        // Soft reset at cycle_count 100, then again at hold cycle 5.
        bus.halt = 1'b0;
        p0 = 0;
        while (bus.cycle_count !== 32'd100 && p0 < 1500) begin
            tick();
            p0++;
        end
        check("sr.reach100", bus.cycle_count, 32'd100);
        prev_ce = last_ce_tick;
        bus.soft_reset = 1'b1;
        tick();
        bus.soft_reset = 1'b0;
        check("sr.cpu_rst_n", bus.cpu_rst_n, 1'b0);
        check("sr.ppu_rst_n", bus.ppu_rst_n, 1'b0);
        check("sr.count",     bus.cycle_count, 32'd0);
        check("sr.state",     bus.run_state, 2'd0);
        wait_cpu_ce(20);
        check("sr.phase", tick_no - prev_ce, 12);
        repeat (4) wait_cpu_ce(20);
        bus.soft_reset = 1'b1;
        tick();
        bus.soft_reset = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            wait_cpu_ce(20);
            check("sr2.ppu_rst_n", bus.ppu_rst_n, (k >= 8));
            check("sr2.cpu_rst_n", bus.cpu_rst_n, (k >= 9));
        end

        // Randomized control traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) bus.halt = ~bus.halt;
            bus.step       = ($urandom_range(0, 5) == 0);
            bus.soft_reset = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 399) == 0) bus.region_pal = ~bus.region_pal;
            tick();
        end

        // Asynchronous reset in the middle of a step, then a clean reboot.
        bus.halt       = 1'b1;
        bus.step       = 1'b0;
        bus.soft_reset = 1'b0;
        bus.region_pal = 1'b0;
        wait_state(2'd2, 2000);
        bus.step = 1'b1;
        wait_state(2'd3, 40);
        bus.step = 1'b0;
        repeat (3) tick();
        async_reset(1'b0);
        check("midstep.state", bus.run_state, 2'd0);
        boot_checks("reboot");

        // PAL chosen before release: first period is NTSC until the first
        // common wrap; a mid-period region change waits for the next one.
        async_reset(1'b1);
        wait_cpu_ce(16);
        check("pal.ce1", tick_no, 12);
        wait_cpu_ce(16);
        check("pal.ce2", tick_no, 28);
        wait_cpu_ce(16);
        check("pal.ce3", tick_no, 44);
        q0 = ppu_pulses;
        while (tick_no < 100) tick();
        check("pal.ppu_span", ppu_pulses - q0, 11);
        bus.region_pal = 1'b0;
        repeat (5) wait_cpu_ce(16);
        check("pal.common", tick_no, 172);
        wait_cpu_ce(16);
        check("ntsc.after", tick_no, 184);
        q0 = ppu_pulses;
        repeat (20) tick();
        check("ntsc.ppu_span", ppu_pulses - q0, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
